// File: rtl/parity_gen_pkg.sv
// -----------------------------------------------------------------------------
// parity_gen_pkg
//   Shared types and helpers for the serial running-parity generator.
//
//   Contents
//     parity_state_t       two-state Moore FSM encoding (EVEN / ODD ones seen)
//     PARITY_STATE_RESET   state entered on reset and at every frame restart
//     next_parity()        one-bit parity accumulation step
//     start_parity()       first step of a freshly restarted frame
//     parity_out()         output decode including the ODD_PARITY inversion
//     frame_cnt_width()    bit counter width for a frame length F
//
//   Configuration macro used by the files that import this package:
//     PARITY_GEN_FRAME_EN  builds the framing counter and frame_done pulse
// -----------------------------------------------------------------------------
package parity_gen_pkg;

  // The state value equals the running parity of the ones seen so far, so
  // the output decode is a plain XOR with the polarity parameter.
  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } parity_state_t;

  localparam parity_state_t PARITY_STATE_RESET = EVEN;

  // A one toggles the accumulated parity, a zero leaves it alone.
  function automatic parity_state_t next_parity(input parity_state_t state,
                                                input logic          x);
    parity_state_t nxt;
    nxt = state;
    if (x) begin
      nxt = (state == EVEN) ? ODD : EVEN;
    end
    return nxt;
  endfunction

  // A new frame discards the old parity and starts accumulating from EVEN,
  // so the bit sampled on the restart edge alone decides the state.
  function automatic parity_state_t start_parity(input logic x);
    return next_parity(PARITY_STATE_RESET, x);
  endfunction

  // Inverting the reported value gives odd-parity generation without
  // touching the state encoding.
  function automatic logic parity_out(input parity_state_t state,
                                      input logic          odd_parity);
    return (state == ODD) ^ odd_parity;
  endfunction

  // The counter only ever holds 0..F-1, but sizing it for F+1 keeps the
  // width at least one bit for F=1 and matches the documented interface.
  function automatic int frame_cnt_width(input int f);
    return (f < 1) ? 1 : $clog2(f + 1);
  endfunction

endpackage

// File: rtl/parity_gen_frame_cnt.sv
// -----------------------------------------------------------------------------
// parity_gen_frame_cnt
//   Bit counter for framed parity generation. Counts every rising clock edge
//   modulo F and raises a registered one-cycle wrap pulse in the cycle that
//   follows the edge sampling the last bit of a frame.
//
//   Parameters
//     F       frame length in bits, must be >= 1
//
//   Ports
//     clk     in   1  clock, rising edge
//     rst_n   in   1  asynchronous reset, active-low
//     wrap    out  1  high for exactly one cycle after bit F-1 was sampled;
//                     with F=1 it stays high from the first edge on
//
//   Only instantiated when PARITY_GEN_FRAME_EN is defined and FRAME_LEN > 0.
// -----------------------------------------------------------------------------
module parity_gen_frame_cnt
  import parity_gen_pkg::*;
#(
  parameter int F = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic wrap
);

  localparam int            CW   = frame_cnt_width(F);
  localparam logic [CW-1:0] LAST = CW'(F - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          wrap_q;
  logic          wrap_d;

  // Next-state of the counter: advance by one each edge and fold back to
  // zero on the last bit of the frame, flagging that a wrap happened. The
  // flag is registered so the top sees it as a state, not a comb path.
  always_comb begin
    cnt_d  = cnt_q + CW'(1);
    wrap_d = 1'b0;
    if (cnt_q == LAST) begin
      cnt_d  = '0;
      wrap_d = 1'b1;
    end
  end

  // Counter and wrap flag registers. Reset puts the counter at bit 0 of a
  // new stream, so the first edge after release samples bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign wrap = wrap_q;

endmodule

// File: rtl/parity_gen.sv
// -----------------------------------------------------------------------------
// parity_gen
//   Serial running-parity generator built as a two-state Moore FSM. One bit
//   of x is sampled on every rising clock edge; z reports the parity of all
//   ones seen since reset or since the last frame restart.
//
//   Parameters
//     ODD_PARITY  0: z=1 when an odd number of ones has been seen
//                 1: z inverted
//     FRAME_LEN   bits per frame when framing is built; 0 = unframed
//
//   Ports
//     clk         in   1  clock, all state updates on the rising edge
//     rst_n       in   1  asynchronous reset, active-low
//     x           in   1  serial data bit, sampled every rising edge
//     z           out  1  registered parity output, straight from the state
//     frame_done  out  1  one-cycle pulse on frame completion, 0 if unframed
//
//   Configuration
//     PARITY_GEN_FRAME_EN  when defined and FRAME_LEN > 0, a bit counter
//                          restarts accumulation every FRAME_LEN bits and
//                          drives frame_done. When undefined, no counter is
//                          built and FRAME_LEN has no effect.
// -----------------------------------------------------------------------------
module parity_gen
  import parity_gen_pkg::*;
#(
  parameter bit ODD_PARITY = 1'b0,
  parameter int FRAME_LEN  = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic x,
  output logic z,
  output logic frame_done
);

  parity_state_t state_q;
  parity_state_t state_d;
  logic          restartFrame;

`ifdef PARITY_GEN_FRAME_EN
  // The counter's wrap pulse is high during the cycle after the last bit of
  // a frame, which is exactly the cycle whose edge must restart accumulation
  // and the cycle in which frame_done is reported.
  if (FRAME_LEN > 0) begin : g_frame
    parity_gen_frame_cnt #(
      .F (FRAME_LEN)
    ) u_frame_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .wrap  (restartFrame)
    );
  end else begin : g_noframe
    assign restartFrame = 1'b0;
  end
`else
  assign restartFrame = 1'b0;
`endif

  // Next-state logic: normally toggle on a one, but on a frame restart the
  // previous parity is dropped and only the current bit counts.
  always_comb begin
    state_d = next_parity(state_q, x);
    if (restartFrame) begin
      state_d = start_parity(x);
    end
  end

  // State register with asynchronous reset to EVEN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PARITY_STATE_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  assign z          = parity_out(state_q, ODD_PARITY);
  assign frame_done = restartFrame;

endmodule

// File: tb/tb_parity_gen.sv
// -----------------------------------------------------------------------------
// tb_parity_gen
//   Self-checking bench for parity_gen. Five instances with different
//   polarity and frame-length settings share clock, reset and data, and are
//   compared against a reference model that keeps the whole bit history
//   since reset and recounts the ones in the current frame.
// -----------------------------------------------------------------------------
module tb_parity_gen;

  localparam int NDUT = 5;
  localparam int ODDS  [NDUT] = '{0, 1, 0, 0, 1};
  localparam int FLENS [NDUT] = '{0, 0, 4, 1, 7};

`ifdef PARITY_GEN_FRAME_EN
  localparam bit FRAMED = 1'b1;
`else
  localparam bit FRAMED = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic x;
  logic zV  [NDUT];
  logic fdV [NDUT];

  int checks;
  int failures;
  bit hist[$];

  parity_gen #(.ODD_PARITY(1'b0), .FRAME_LEN(0)) uA (
    .clk(clk), .rst_n(rst_n), .x(x), .z(zV[0]), .frame_done(fdV[0]));
  parity_gen #(.ODD_PARITY(1'b1), .FRAME_LEN(0)) uB (
    .clk(clk), .rst_n(rst_n), .x(x), .z(zV[1]), .frame_done(fdV[1]));
  parity_gen #(.ODD_PARITY(1'b0), .FRAME_LEN(4)) uC (
    .clk(clk), .rst_n(rst_n), .x(x), .z(zV[2]), .frame_done(fdV[2]));
  parity_gen #(.ODD_PARITY(1'b0), .FRAME_LEN(1)) uD (
    .clk(clk), .rst_n(rst_n), .x(x), .z(zV[3]), .frame_done(fdV[3]));
  parity_gen #(.ODD_PARITY(1'b1), .FRAME_LEN(7)) uE (
    .clk(clk), .rst_n(rst_n), .x(x), .z(zV[4]), .frame_done(fdV[4]));

  // Free-running 10 ns clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected z: parity of the ones in the current frame (or the whole
  // history when unframed), inverted for odd-parity instances.
  function automatic logic expZ(input int idx);
    int n;
    int start;
    int ones;
    n     = hist.size();
    start = 0;
    ones  = 0;
    if (FRAMED && FLENS[idx] > 0 && n > 0) begin
      start = ((n - 1) / FLENS[idx]) * FLENS[idx];
    end
    for (int i = start; i < n; i++) begin
      ones += int'(hist[i]);
    end
    return logic'((ones % 2) ^ ODDS[idx]);
  endfunction

  // Expected frame_done: high after every edge that completes a frame.
  function automatic logic expFd(input int idx);
    int n;
    n = hist.size();
    if (FRAMED && FLENS[idx] > 0 && n > 0) begin
      return logic'((n % FLENS[idx]) == 0);
    end
    return 1'b0;
  endfunction

  task automatic checkValue(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string ctx);
    for (int i = 0; i < NDUT; i++) begin
      checkValue($sformatf("%s.dut%0d.z", ctx, i), zV[i], expZ(i));
      checkValue($sformatf("%s.dut%0d.frame_done", ctx, i), fdV[i], expFd(i));
    end
  endtask

  // Called just after a falling edge: drive the bit mid-period, let the
  // rising edge sample it, check 1 ns later, and return on the next fall.
  task automatic applyStimulus(input logic b, input string ctx);
    x = b;
    @(posedge clk);
    #1;
    hist.push_back(bit'(b));
    checkOutput(ctx);
    @(negedge clk);
  endtask

  // Called just after a falling edge: assert reset between edges, check the
  // outputs before any clock edge, then release on the next falling edge so
  // the following rising edge samples bit 0 of a new stream.
  task automatic pulseReset(input string ctx);
    #2;
    rst_n = 1'b0;
    #1;
    hist.delete();
    checkOutput(ctx);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int s2x [12] = '{0, 1, 1, 1, 0, 1, 1, 0, 0, 1, 1, 0};
  int s2z [12] = '{0, 1, 0, 1, 1, 0, 1, 1, 1, 0, 1, 1};
  int s4x [8]  = '{1, 1, 1, 0, 1, 0, 0, 0};
`ifdef PARITY_GEN_FRAME_EN
  int s4z [8]  = '{1, 0, 1, 1, 1, 1, 1, 1};
  int s4fd[8]  = '{0, 0, 0, 1, 0, 0, 0, 1};
`else
  int s4z [8]  = '{1, 0, 1, 1, 0, 0, 0, 0};
  int s4fd[8]  = '{0, 0, 0, 0, 0, 0, 0, 0};
`endif

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    x        = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("[TB] asynchronous reset without a clock edge");
    pulseReset("reset");
    checkValue("reset.uA.z_const", zV[0], 1'b0);

    $display("[TB] unframed stream, both polarities");
    for (int k = 0; k < 12; k++) begin
      applyStimulus(logic'(s2x[k]), $sformatf("s2.bit%0d", k));
      checkValue($sformatf("s2.uA.z.bit%0d", k), zV[0], logic'(s2z[k]));
      checkValue($sformatf("s3.uB.z.bit%0d", k), zV[1], ~logic'(s2z[k]));
    end

    $display("[TB] two frames of four bits");
    pulseReset("s4.reset");
    for (int k = 0; k < 8; k++) begin
      applyStimulus(logic'(s4x[k]), $sformatf("s4.bit%0d", k));
      checkValue($sformatf("s4.uC.z.bit%0d", k), zV[2], logic'(s4z[k]));
      checkValue($sformatf("s4.uC.fd.bit%0d", k), fdV[2], logic'(s4fd[k]));
    end

    $display("[TB] reset in the middle of a stream");
    pulseReset("s5.reset0");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, $sformatf("s5.pre%0d", k));
    end
    pulseReset("s5.reset1");
    checkValue("s5.uA.z_at_reset", zV[0], 1'b0);
    applyStimulus(1'b1, "s5.post0");
    checkValue("s5.uA.z_after_one", zV[0], 1'b1);
    for (int k = 1; k < 4; k++) begin
      applyStimulus(1'b0, $sformatf("s5.post%0d", k));
    end
    checkValue("s5.uC.fd_4th_edge", fdV[2], logic'(FRAMED));

    $display("[TB] random 1000-bit stream");
    for (int k = 0; k < 1000; k++) begin
      if (k == 500) begin
        pulseReset("rand.reset");
      end
      applyStimulus(logic'($urandom_range(0, 1)), $sformatf("rand.bit%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
